operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width.
REQ-002 SHALL have parameter depth, default 5: register index width; 1<<depth registers.
REQ-003 SHALL have parameter TAG_W, default 32: width of the sideband tag carried with each request (e.g. PC).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream request valid.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 in_rs1, in_rs2  input  depth each  source register indices.
REQ-009 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-010 rs1_addr, rs2_addr  output  depth each  read addresses to the synchronous register-file RAM.
REQ-011 rs1_data, rs2_data  input  XLEN each  RAM read data, valid one cycle after address.
REQ-012 wb_we, wb_addr, wb_data  input  1/depth/XLEN  snoop of the RAM write port (same signals that drive it).
REQ-013 out_valid  output  1  operands valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 out_rs1, out_rs2, out_tag  output  XLEN/XLEN/TAG_W  operands and tag.

Function
REQ-016 One pending-request register (valid bit, both indices, tag); throughput one request per cycle when out_ready held high.
REQ-017 in_ready SHALL be combinational: !pend_valid || (out_valid && out_ready).
REQ-018 rs1_addr/rs2_addr SHALL equal in_rs1/in_rs2 when in_ready, else the pending indices (re-read every stalled cycle).
REQ-019 Latency: request accepted in cycle N SHALL present out_valid in cycle N+1 at earliest.
REQ-020 Operand source priority per port: index 0 -> zero; bypass flag set -> captured bypass data; else RAM data.
REQ-021 Bypass flag SHALL set at edge ending cycle N when wb_we && wb_addr == address presented in cycle N && wb_addr != 0; wb_data captured same edge; cleared otherwise.
REQ-022 Since addresses are re-read while stalled, held operands SHALL reflect every write completed before the cycle they are presented.
REQ-023 out_rs1/out_rs2 SHALL be 0 whenever out_valid is 0; out_tag holds last pending tag.
REQ-024 Request and write to same index in same cycle: write value wins (bypass), never old RAM contents.
REQ-025 Writes to index 0 SHALL never bypass; x0 always reads 0.
REQ-026 Simultaneous output fire and new accept SHALL replace pending entry without bubble.
REQ-027 out_valid SHALL not drop, and out_* SHALL change only per REQ-022, until fired.

Reset
REQ-028 Assertion of rst_n low SHALL immediately clear pending valid and bypass flags, out_valid=0, out_rs1=out_rs2=0, out_tag=0, in_ready=1.
REQ-029 Reset mid-operation SHALL drop the pending request; no output for it after release.
REQ-030 First request accepted in the first cycle after rst_n rises.

Configuration
REQ-031 Macro OPERAND_FETCH_BYPASS_EN defined: same-cycle write bypass per REQ-021.
REQ-032 Macro undefined: no bypass registers; a match per REQ-021 SHALL instead set a stale flag forcing out_valid=0 for the next cycle, the address being re-read (in_ready=0); result identical values, one extra cycle per hit.

Verification
REQ-033 Reset then RAM x5=0x11, request rs1=5 rs2=0 tag=0x100, out_ready=1 -> next cycle out_valid=1, out_rs1=0x11, out_rs2=0, out_tag=0x100.
REQ-034 Request rs1=7 in same cycle as write x7=0xAB -> out_rs1=0xAB (with macro: N+1; without: N+2, out_valid low at N+1).
REQ-035 Hold out_ready=0 three cycles with pending rs2=3, write x3=0x55 in second stall cycle -> out_rs2 becomes 0x55, in_ready=0 throughout, out_valid steady.
REQ-036 Back-to-back 4 requests, out_ready=1 -> 4 consecutive out_valid cycles, correct tags in order, in_ready constant 1.
REQ-037 Write x0=0xFF with concurrent request rs1=0 -> out_rs1=0.
REQ-038 Pull rst_n low while out_valid=1 stalled -> out_valid=0 same cycle, out_rs1=out_rs2=0, in_ready=1; no stale output after release.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: single-entry operand fetch stage in front of a synchronous
// register-file RAM (one cycle read latency, read-first on a same-address write).
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             request handshake
//   in_rs1, in_rs2, in_tag        source indices and sideband tag
//   rs1_addr, rs2_addr            read addresses to the RAM
//   rs1_data, rs2_data            RAM read data (one cycle after address)
//   wb_we, wb_addr, wb_data       snoop of the RAM write port
//   out_valid/out_ready           operand handshake
//   out_rs1, out_rs2, out_tag     operands (zero while out_valid is low) and tag
//
// Build option: OPERAND_FETCH_BYPASS_EN
//   defined   : a write hitting the address presented this cycle is captured
//               and forwarded next cycle (no stall).
//   undefined : such a hit raises a stale flag that holds out_valid low for one
//               cycle while the address is re-read from the RAM.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int depth = 5,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [depth-1:0] in_rs1,
  input  logic [depth-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [depth-1:0] rs1_addr,
  output logic [depth-1:0] rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             wb_we,
  input  logic [depth-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rs1,
  output logic [XLEN-1:0]  out_rs2,
  output logic [TAG_W-1:0] out_tag
);

  logic             pend_valid;
  logic [depth-1:0] pend_rs1;
  logic [depth-1:0] pend_rs2;
  logic [TAG_W-1:0] pend_tag;
  logic             accept;
  logic             fire;
  logic             hit1;
  logic             hit2;

  // x0 reads as zero, a forwarded write beats the RAM, otherwise RAM data.
  function automatic logic [XLEN-1:0] operand_sel(
    input logic [depth-1:0] idx,
    input logic             byp,
    input logic [XLEN-1:0]  byp_data,
    input logic [XLEN-1:0]  ram_data
  );
    if (idx == '0)
      return '0;
    else if (byp)
      return byp_data;
    else
      return ram_data;
  endfunction

  assign fire     = out_valid && out_ready;
  assign in_ready = !pend_valid || fire;
  assign accept   = in_valid && in_ready;

  // While stalled the pending indices are re-read every cycle, so the RAM data
  // seen next cycle always belongs to whatever is pending then.
  assign rs1_addr = in_ready ? in_rs1 : pend_rs1;
  assign rs2_addr = in_ready ? in_rs2 : pend_rs2;

  // A write to the address being read this cycle is missed by the read-first
  // RAM; x0 writes are ignored since x0 is forced to zero anyway.
  assign hit1 = wb_we && (wb_addr == rs1_addr) && (wb_addr != '0);
  assign hit2 = wb_we && (wb_addr == rs2_addr) && (wb_addr != '0);

  // ---- pending request register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_tag   <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_tag   <= in_tag;
    end else if (fire) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_rs1 <= in_rs1;
      pend_rs2 <= in_rs2;
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  logic            byp1_vld;
  logic            byp2_vld;
  logic [XLEN-1:0] byp1_data;
  logic [XLEN-1:0] byp2_data;

  // ---- write bypass capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp1_vld <= 1'b0;
      byp2_vld <= 1'b0;
    end else begin
      byp1_vld <= hit1;
      byp2_vld <= hit2;
    end
  end

  // Data is only consumed when the matching flag is set.
  always_ff @(posedge clk) begin
    byp1_data <= wb_data;
    byp2_data <= wb_data;
  end

  assign out_valid = pend_valid;
  assign out_rs1   = out_valid ? operand_sel(pend_rs1, byp1_vld, byp1_data, rs1_data) : '0;
  assign out_rs2   = out_valid ? operand_sel(pend_rs2, byp2_vld, byp2_data, rs2_data) : '0;
`else
  logic stale;
  logic unused_wb_data;

  // ---- stale flag: RAM data this cycle predates a write, re-read instead ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stale <= 1'b0;
    else
      stale <= hit1 || hit2;
  end

  // Write data is not needed without forwarding registers.
  assign unused_wb_data = ^wb_data;

  assign out_valid = pend_valid && !stale;
  assign out_rs1   = out_valid ? operand_sel(pend_rs1, 1'b0, '0, rs1_data) : '0;
  assign out_rs2   = out_valid ? operand_sel(pend_rs2, 1'b0, '0, rs2_data) : '0;
`endif

  assign out_tag = pend_tag;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural read-first register RAM.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2;
  logic [31:0] in_tag;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1, out_rs2, out_tag;

  logic [31:0] ram [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .depth(5), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_tag(out_tag)
  );

  // Synchronous read-first register file.
  always @(posedge clk) begin
    if (wb_we) ram[wb_addr] <= wb_data;
    rs1_data <= ram[rs1_addr];
    rs2_data <= ram[rs2_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_tag = 32'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    n_checks++; if (out_rs1 !== 32'd0) begin n_fail++; $display("FAIL reset_out_rs1 got=%0h exp=0", out_rs1); end
    n_checks++; if (out_tag !== 32'd0) begin n_fail++; $display("FAIL reset_out_tag got=%0h exp=0", out_tag); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_tag = 32'h100;
    #1;
    n_checks++; if (rs1_addr !== 5'd5) begin n_fail++; $display("FAIL basic_rs1_addr got=%0h exp=5", rs1_addr); end
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1 !== 32'h11) begin n_fail++; $display("FAIL basic_rs1 got=%0h exp=11", out_rs1); end
    n_checks++; if (out_rs2 !== 32'h0) begin n_fail++; $display("FAIL basic_rs2 got=%0h exp=0", out_rs2); end
    n_checks++; if (out_tag !== 32'h100) begin n_fail++; $display("FAIL basic_tag got=%0h exp=100", out_tag); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%0h exp=0", out_valid); end
    n_checks++; if (out_rs1 !== 32'h0) begin n_fail++; $display("FAIL basic_rs1_idle got=%0h exp=0", out_rs1); end
  endtask

  task automatic test_write_bypass;
    out_ready = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0; in_tag = 32'h200;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAB;
    tick();
    idle();
`ifndef OPERAND_FETCH_BYPASS_EN
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_stale_valid got=%0h exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL byp_stale_ready got=%0h exp=0", in_ready); end
    n_checks++; if (out_rs1 !== 32'h0) begin n_fail++; $display("FAIL byp_stale_rs1 got=%0h exp=0", out_rs1); end
    tick();
`endif
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1 !== 32'hAB) begin n_fail++; $display("FAIL byp_rs1 got=%0h exp=ab", out_rs1); end
    n_checks++; if (out_tag !== 32'h200) begin n_fail++; $display("FAIL byp_tag got=%0h exp=200", out_tag); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd3; in_tag = 32'h300;
    tick();
    idle();
    // first stall cycle
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall1_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs2 !== 32'h33) begin n_fail++; $display("FAIL stall1_rs2 got=%0h exp=33", out_rs2); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall1_ready got=%0h exp=0", in_ready); end
    tick();
    // second stall cycle: write x3 while it is being re-read
    n_checks++; if (rs2_addr !== 5'd3) begin n_fail++; $display("FAIL stall2_addr got=%0h exp=3", rs2_addr); end
    n_checks++; if (out_rs2 !== 32'h33) begin n_fail++; $display("FAIL stall2_rs2 got=%0h exp=33", out_rs2); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall2_ready got=%0h exp=0", in_ready); end
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall3_ready got=%0h exp=0", in_ready); end
`ifdef OPERAND_FETCH_BYPASS_EN
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall3_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs2 !== 32'h55) begin n_fail++; $display("FAIL stall3_rs2 got=%0h exp=55", out_rs2); end
`else
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall3_valid got=%0h exp=0", out_valid); end
`endif
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall4_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs2 !== 32'h55) begin n_fail++; $display("FAIL stall4_rs2 got=%0h exp=55", out_rs2); end
    n_checks++; if (out_tag !== 32'h300) begin n_fail++; $display("FAIL stall4_tag got=%0h exp=300", out_tag); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall4_ready got=%0h exp=0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_tag, exp_rs1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rs1 = 5'(8 + i); in_rs2 = 5'd0; in_tag = 32'h400 + 32'(i);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, in_ready); end
      if (i > 0) begin
        exp_tag = 32'h400 + 32'(i - 1);
        exp_rs1 = 32'h1000 + 32'(i - 1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, out_valid); end
        n_checks++; if (out_tag !== exp_tag) begin n_fail++; $display("FAIL b2b_tag[%0d] got=%0h exp=%0h", i, out_tag, exp_tag); end
        n_checks++; if (out_rs1 !== exp_rs1) begin n_fail++; $display("FAIL b2b_rs1[%0d] got=%0h exp=%0h", i, out_rs1, exp_rs1); end
      end
      tick();
    end
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_tag !== 32'h403) begin n_fail++; $display("FAIL b2b_last_tag got=%0h exp=403", out_tag); end
    n_checks++; if (out_rs1 !== 32'h1003) begin n_fail++; $display("FAIL b2b_last_rs1 got=%0h exp=1003", out_rs1); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_x0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_tag = 32'h500;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1 !== 32'h0) begin n_fail++; $display("FAIL x0_rs1 got=%0h exp=0", out_rs1); end
    n_checks++; if (out_rs2 !== 32'h0) begin n_fail++; $display("FAIL x0_rs2 got=%0h exp=0", out_rs2); end
    n_checks++; if (out_tag !== 32'h500) begin n_fail++; $display("FAIL x0_tag got=%0h exp=500", out_tag); end
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd3; in_tag = 32'h600;
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1 !== 32'h11) begin n_fail++; $display("FAIL rmid_pre_rs1 got=%0h exp=11", out_rs1); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%0h exp=0", out_valid); end
    n_checks++; if (out_rs1 !== 32'h0) begin n_fail++; $display("FAIL rmid_rs1 got=%0h exp=0", out_rs1); end
    n_checks++; if (out_rs2 !== 32'h0) begin n_fail++; $display("FAIL rmid_rs2 got=%0h exp=0", out_rs2); end
    n_checks++; if (out_tag !== 32'h0) begin n_fail++; $display("FAIL rmid_tag got=%0h exp=0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%0h exp=1", in_ready); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_post_valid got=%0h exp=0", out_valid); end
    // first request right after release
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_tag = 32'h700;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got=%0h exp=1", in_ready); end
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid got=%0h exp=1", out_valid); end
    n_checks++; if (out_rs1 !== 32'h11) begin n_fail++; $display("FAIL rel_rs1 got=%0h exp=11", out_rs1); end
    n_checks++; if (out_tag !== 32'h700) begin n_fail++; $display("FAIL rel_tag got=%0h exp=700", out_tag); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_drain got=%0h exp=0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle();
    #12;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    write_reg(5'd5, 32'h11);
    write_reg(5'd7, 32'h01);
    write_reg(5'd3, 32'h33);
    for (int i = 0; i < 4; i++) write_reg(5'(8 + i), 32'h1000 + 32'(i));
    tick();
    test_basic();
    test_write_bypass();
    test_stall();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
